// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_controller
//   Stall/flush sequencer for the PC, IF/ID, ID/EX and EX/MEM barriers.
//   Optional stallCycles counter is built when HAZARD_STALL_COUNTER_EN is defined.
//   Revision: 1.0
// ============================================================================
module pipeline_hazard_controller #(
    parameter int MAX_MEM_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] idLHSRegisterIndex,
    input  logic [4:0] idRHSRegisterIndex,
    input  logic       idUsesLHS,
    input  logic       idUsesRHS,
    input  logic       exMemRead,
    input  logic [4:0] exWriteRegisterIndex,
    input  logic       branchTaken,
    input  logic       memBusy,
    output logic       pcWrite,
    output logic       ifIdWrite,
    output logic       idExWrite,
    output logic       exMemWrite,
    output logic       ifIdFlush,
    output logic       idExFlush,
    output logic [1:0] controllerState,
    output logic       memTimeout
`ifdef HAZARD_STALL_COUNTER_EN
    ,
    output logic [31:0] stallCycles
`endif
);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd1;
    localparam logic [1:0] ST_LOAD_STALL = 2'd2;
    localparam logic [1:0] ST_FLUSH      = 2'd3;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_MEM_WAIT);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] wait_cnt;
    logic       load_use;
    logic       load_use_armed;

    assign load_use = exMemRead && (exWriteRegisterIndex != 5'd0) &&
                      ((idUsesLHS && (idLHSRegisterIndex == exWriteRegisterIndex)) ||
                       (idUsesRHS && (idRHSRegisterIndex == exWriteRegisterIndex)));

    // One cycle of suppression after a bubble/flush keeps a held load from stalling twice.
    assign load_use_armed = load_use && (state != ST_LOAD_STALL) && (state != ST_FLUSH);

    assign controllerState = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt   <= 8'd0;
            memTimeout <= 1'b0;
        end else if (memBusy) begin
            if (wait_cnt == WAIT_LIMIT) begin
                memTimeout <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    always_comb begin
        state_next = ST_RUN;
        if (memBusy) begin
            state_next = ST_MEM_WAIT;
        end else if (branchTaken) begin
            state_next = ST_FLUSH;
        end else if (load_use_armed) begin
            state_next = ST_LOAD_STALL;
        end
    end

    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        idExWrite  = 1'b1;
        exMemWrite = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        if (reset) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
        end else if (memBusy) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
        end else if (branchTaken) begin
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
        end else if (load_use_armed) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExFlush  = 1'b1;
        end
    end

`ifdef HAZARD_STALL_COUNTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCycles <= 32'd0;
        end else if (!pcWrite) begin
            stallCycles <= stallCycles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_controller
//   Directed plus random stimulus against a rule-level model; scoreboard queue.
//   Revision: 1.0
// ============================================================================
module tb_pipeline_hazard_controller;

    localparam int MAXW = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] idLHSRegisterIndex = 5'd0;
    logic [4:0] idRHSRegisterIndex = 5'd0;
    logic       idUsesLHS = 1'b0;
    logic       idUsesRHS = 1'b0;
    logic       exMemRead = 1'b0;
    logic [4:0] exWriteRegisterIndex = 5'd0;
    logic       branchTaken = 1'b0;
    logic       memBusy = 1'b0;
    logic       pcWrite, ifIdWrite, idExWrite, exMemWrite, ifIdFlush, idExFlush;
    logic [1:0] controllerState;
    logic       memTimeout;
    logic [31:0] stallCycles;

    pipeline_hazard_controller #(.MAX_MEM_WAIT(MAXW)) dut (
        .clk(clk),
        .reset(reset),
        .idLHSRegisterIndex(idLHSRegisterIndex),
        .idRHSRegisterIndex(idRHSRegisterIndex),
        .idUsesLHS(idUsesLHS),
        .idUsesRHS(idUsesRHS),
        .exMemRead(exMemRead),
        .exWriteRegisterIndex(exWriteRegisterIndex),
        .branchTaken(branchTaken),
        .memBusy(memBusy),
        .pcWrite(pcWrite),
        .ifIdWrite(ifIdWrite),
        .idExWrite(idExWrite),
        .exMemWrite(exMemWrite),
        .ifIdFlush(ifIdFlush),
        .idExFlush(idExFlush),
        .controllerState(controllerState),
        .memTimeout(memTimeout)
`ifdef HAZARD_STALL_COUNTER_EN
        ,
        .stallCycles(stallCycles)
`endif
    );

`ifndef HAZARD_STALL_COUNTER_EN
    assign stallCycles = 32'd0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        bit [5:0]    en_fl;   // pc, ifid, idex, exmem, ifIdFlush, idExFlush
        int          st;
        bit          to;
        int unsigned stall;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Model: what the previous cycle did, consecutive busy-run length, sticky timeout.
    int          prev_kind = 0;
    int          busy_run = 0;
    bit          m_to = 1'b0;
    int unsigned m_stall = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit busy, input bit br, input bit mr,
                         input bit ul, input bit ur, input bit [4:0] ls,
                         input bit [4:0] rs, input bit [4:0] wd);
        exp_t e;
        bit   lu;
        int   kind;
        @(posedge clk);
        #1;
        reset = r; memBusy = busy; branchTaken = br; exMemRead = mr;
        idUsesLHS = ul; idUsesRHS = ur; idLHSRegisterIndex = ls;
        idRHSRegisterIndex = rs; exWriteRegisterIndex = wd;
        if (r) begin
            prev_kind = 0; busy_run = 0; m_to = 1'b0; m_stall = 0;
            e.en_fl = 6'b0000_11; e.st = 0; e.to = 1'b0; e.stall = 0;
        end else begin
            e.st = prev_kind; e.to = m_to; e.stall = m_stall;
            lu = mr && (wd != 0) && ((ul && ls == wd) || (ur && rs == wd));
            if (busy) begin
                e.en_fl = 6'b0000_00; kind = 1;
            end else if (br) begin
                e.en_fl = 6'b1111_11; kind = 3;
            end else if (lu && prev_kind != 2 && prev_kind != 3) begin
                e.en_fl = 6'b0011_01; kind = 2;
            end else begin
                e.en_fl = 6'b1111_00; kind = 0;
            end
            if (busy) begin
                if (busy_run >= MAXW) m_to = 1'b1;
                busy_run++;
            end else begin
                busy_run = 0;
            end
            if (!e.en_fl[5]) m_stall++;
            prev_kind = kind;
        end
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pcWrite",    32'(pcWrite),    32'(e.en_fl[5]));
                chk("ifIdWrite",  32'(ifIdWrite),  32'(e.en_fl[4]));
                chk("idExWrite",  32'(idExWrite),  32'(e.en_fl[3]));
                chk("exMemWrite", 32'(exMemWrite), 32'(e.en_fl[2]));
                chk("ifIdFlush",  32'(ifIdFlush),  32'(e.en_fl[1]));
                chk("idExFlush",  32'(idExFlush),  32'(e.en_fl[0]));
                chk("state",      32'(controllerState), 32'(e.st));
                chk("memTimeout", 32'(memTimeout), 32'(e.to));
`ifdef HAZARD_STALL_COUNTER_EN
                chk("stallCycles", stallCycles, e.stall);
`endif
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int burst;
        bit busy;
        burst = 0;
        // reset, then load-use with inputs held for a second cycle
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 5, 0, 5);
        cycle(0, 0, 0, 1, 1, 0, 5, 0, 5);
        cycle(0, 0, 0, 1, 1, 0, 5, 0, 5);
        // x0 destination and unused rs2 never stall
        cycle(0, 0, 0, 1, 1, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 3, 7, 7);
        cycle(0, 0, 0, 1, 0, 1, 7, 9, 7);
        // branch with simultaneous load-use
        cycle(0, 0, 1, 1, 1, 0, 4, 0, 4);
        cycle(0, 0, 0, 1, 1, 0, 4, 0, 4);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // busy with branch pending: freeze, then branch flush once busy drops
        repeat (3) cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // timeout: MAXW+2 busy cycles, flag sticks afterwards
        repeat (MAXW + 2) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset mid memory wait, then release
        repeat (2) cycle(0, 1, 0, 1, 1, 0, 2, 0, 2);
        cycle(1, 1, 0, 1, 1, 0, 2, 0, 2);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // random traffic with bursty memory waits and rare resets
        for (int i = 0; i < 3000; i++) begin
            if (burst > 0) begin
                busy = 1'b1; burst--;
            end else if ($urandom_range(0, 7) == 0) begin
                busy = 1'b1; burst = $urandom_range(0, 5);
            end else begin
                busy = 1'b0;
            end
            cycle(($urandom_range(0, 199) == 0), busy, ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage pipeline. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM barriers. Three conditions are resolved in fixed priority: data-memory wait, taken branch and load-use hazard. A small state machine tracks multi-cycle memory waits and flags a timeout when one runs too long.

## Interface
Parameters:
- MAX_MEM_WAIT, 15, memBusy cycles tolerated before memTimeout sets (1..255)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high
- idLHSRegisterIndex  input  5  rs1 of instruction in ID
- idRHSRegisterIndex  input  5  rs2 of instruction in ID
- idUsesLHS  input  1  ID instruction reads rs1
- idUsesRHS  input  1  ID instruction reads rs2
- exMemRead  input  1  instruction in EX is a load
- exWriteRegisterIndex  input  5  destination of instruction in EX
- branchTaken  input  1  branch/jump resolved taken in EX this cycle
- memBusy  input  1  data memory not ready this cycle
- pcWrite  output  1  PC update enable
- ifIdWrite  output  1  IF/ID barrier load enable
- idExWrite  output  1  ID/EX barrier load enable
- exMemWrite  output  1  EX/MEM barrier load enable
- ifIdFlush  output  1  IF/ID loads a bubble
- idExFlush  output  1  ID/EX loads a bubble (all control bits 0)
- controllerState  output  2  current FSM state (encoding below)
- memTimeout  output  1  sticky memory-wait timeout flag

## Operation
- States: RUN=0, MEM_WAIT=1, LOAD_STALL=2, FLUSH=3.
- loadUse = exMemRead & (exWriteRegisterIndex != 0) & ((idUsesLHS & idLHSRegisterIndex == exWriteRegisterIndex) | (idUsesRHS & idRHSRegisterIndex == exWriteRegisterIndex)).
- Outputs are combinational from the current state and inputs. Evaluation in any state (priority high to low):
  1. memBusy=1: all four write enables 0, both flushes 0. Next state MEM_WAIT.
  2. branchTaken=1: all enables 1, ifIdFlush=1, idExFlush=1. Next state FLUSH.
  3. loadUse=1 and state is not LOAD_STALL/FLUSH: pcWrite=0, ifIdWrite=0, idExWrite=1, exMemWrite=1, idExFlush=1. Next state LOAD_STALL.
  4. Otherwise: all enables 1, flushes 0. Next state RUN.
- LOAD_STALL and FLUSH suppress loadUse detection for exactly one cycle, which guarantees one bubble per load. memBusy and branchTaken are still honoured in these states.
- Wait counter (8-bit):
  - Cleared to 0 in any cycle with memBusy=0.
  - Increments each memBusy=1 cycle and saturates at MAX_MEM_WAIT.
  - A memBusy=1 cycle with the counter already at MAX_MEM_WAIT sets memTimeout.
- memTimeout is cleared only by reset. It does not alter stall behaviour.
- While reset=1: state RUN, counter 0, memTimeout 0, all write enables 0, ifIdFlush=1, idExFlush=1.

## Timing
- Zero latency for hazard response: enables and flushes respond in the same cycle the condition is present. State updates on the rising edge.
- Load-use costs exactly 1 stall cycle. Taken branch costs 2 flushed slots in the same cycle.
- A memBusy run of N cycles freezes the pipeline for exactly N cycles. On the first cycle with memBusy=0, RUN-priority evaluation applies.
- memBusy and branchTaken high together: freeze wins. The branch is re-evaluated on the first non-busy cycle, because EX is held.
- Timeout: memTimeout rises on the edge after the (MAX_MEM_WAIT+1)-th consecutive busy cycle.
- Reset asserted mid-stall forces outputs to reset values immediately (asynchronous). After deassertion, the first edge sees state RUN.

## Configuration
- HAZARD_STALL_COUNTER_EN defined:
  - Adds output stallCycles (32 bits). It counts cycles with reset=0 and pcWrite=0, and wraps 0xFFFFFFFF→0.
  - Reset value is 0.
- HAZARD_STALL_COUNTER_EN not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Load-use: exMemRead=1, exWriteRegisterIndex=5, idLHSRegisterIndex=5, idUsesLHS=1 → that cycle pcWrite=0, ifIdWrite=0, idExFlush=1. Next cycle state=2 and all enables 1 even with inputs held.
- x0 and unused operand: exWriteRegisterIndex=0 matching rs1=0 → no stall. Match on rs2 with idUsesRHS=0 → no stall.
- Branch: branchTaken=1 for 1 cycle → ifIdFlush=idExFlush=1, pcWrite=1, state=3 next. A simultaneous loadUse is ignored.
- Memory wait: memBusy=1 for 4 cycles with branchTaken=1 → 4 frozen cycles with flushes 0. Then branch flush is taken on cycle 5. memTimeout stays 0.
- Timeout: MAX_MEM_WAIT=3, memBusy=1 for 5 cycles → memTimeout=1 after the 4th busy edge. It stays 1 after memBusy=0 until reset.
- Reset mid-MEM_WAIT: assert reset between edges → enables 0 and flushes 1 immediately. After release: state=0, memTimeout=0, and stallCycles=0 when enabled.
